regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_pkg.sv | 18 +
 rtl/regfile_wsel.sv | 34 +++
 rtl/regfile_sb.sv | 99 +++++++++
 tb/tb_regfile_sb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// regfile_sb_pkg : shared constants and bus-slicing helper for regfile_sb
// Revision: 1.0
// ============================================================================
package regfile_sb_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_REGBITS = 3;
  localparam int C_ZERO_REG      = 0;

  // Low bit index of element idx in a flattened bus of w-bit elements.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wsel.sv
`default_nettype none
// ============================================================================
// regfile_wsel : resolves which write port targets one register address
// Revision: 1.0
// ============================================================================
module regfile_wsel
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int REGBITS = DEFAULT_REGBITS,
  parameter int NWR     = 2
) (
  input  logic [NWR-1:0]         i_we,
  input  logic [NWR*REGBITS-1:0] i_wa,
  input  logic [NWR*WIDTH-1:0]   i_wd,
  input  logic [REGBITS-1:0]     i_sel_addr,
  output logic                   o_hit,
  output logic [WIDTH-1:0]       o_data
);

  // Later ports overwrite earlier matches, so the highest index wins.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int k = 0; k < NWR; k++) begin
      if (i_we[k] && (i_wa[slice_lo(k, REGBITS) +: REGBITS] == i_sel_addr)) begin
        o_hit  = 1'b1;
        o_data = i_wd[slice_lo(k, WIDTH) +: WIDTH];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// regfile_sb : multi-port register file with write bypass and busy scoreboard
// Revision: 1.0
// ============================================================================
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int REGBITS = DEFAULT_REGBITS,
  parameter int NRD     = 2,
  parameter int NWR     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD*REGBITS-1:0] ra_i,
  output logic [NRD*WIDTH-1:0]   rd_o,
  output logic [NRD-1:0]         rd_busy_o,
  input  logic [NWR-1:0]         we_i,
  input  logic [NWR*REGBITS-1:0] wa_i,
  input  logic [NWR*WIDTH-1:0]   wd_i,
  input  logic                   issue_i,
  input  logic [REGBITS-1:0]     issue_wa_i,
  output logic [2**REGBITS-1:0]  busy_o
);

  localparam int NREGS = 2**REGBITS;

  logic             w_hit   [NREGS];
  logic [WIDTH-1:0] w_wdata [NREGS];
  logic [WIDTH-1:0] w_regs  [NREGS];
  logic             w_busy  [NREGS];

  generate
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
      if (r == C_ZERO_REG) begin : g_zero
        assign w_hit[r]   = 1'b0;
        assign w_wdata[r] = '0;
        assign w_regs[r]  = '0;
        assign w_busy[r]  = 1'b0;
        assign busy_o[r]  = 1'b0;
      end else begin : g_live
        logic [WIDTH-1:0] r_q;
        logic             r_busy;

        regfile_wsel #(
          .WIDTH   (WIDTH),
          .REGBITS (REGBITS),
          .NWR     (NWR)
        ) u_wsel (
          .i_we       (we_i),
          .i_wa       (wa_i),
          .i_wd       (wd_i),
          .i_sel_addr (REGBITS'(r)),
          .o_hit      (w_hit[r]),
          .o_data     (w_wdata[r])
        );

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_q <= '0;
          end else if (w_hit[r]) begin
            r_q <= w_wdata[r];
          end
        end

        // A new issue outranks the write retiring the previous one.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_busy <= 1'b0;
          end else if (issue_i && (issue_wa_i == REGBITS'(r))) begin
            r_busy <= 1'b1;
          end else if (w_hit[r]) begin
            r_busy <= 1'b0;
          end
        end

        assign w_regs[r] = r_q;
        assign w_busy[r] = r_busy;
        assign busy_o[r] = r_busy;
      end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [REGBITS-1:0] w_ra;
      logic               w_byp;

      assign w_ra  = ra_i[slice_lo(k, REGBITS) +: REGBITS];
      assign w_byp = w_hit[w_ra];

      // Bypass is gated by rst so in-flight writes cannot leak out during reset.
      assign rd_o[slice_lo(k, WIDTH) +: WIDTH] = rst   ? '0 :
                                                 w_byp ? w_wdata[w_ra] : w_regs[w_ra];
      assign rd_busy_o[k] = !rst && w_busy[w_ra] && !w_byp;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// tb_regfile_sb : directed bench with behavioural model and per-cycle compare
// Revision: 1.0
// ============================================================================
module tb_regfile_sb;

  localparam int WIDTH   = 32;
  localparam int REGBITS = 3;
  localparam int NRD     = 2;
  localparam int NWR     = 2;
  localparam int NREGS   = 2**REGBITS;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NRD*REGBITS-1:0] ra_i;
  logic [NRD*WIDTH-1:0]   rd_o;
  logic [NRD-1:0]         rd_busy_o;
  logic [NWR-1:0]         we_i;
  logic [NWR*REGBITS-1:0] wa_i;
  logic [NWR*WIDTH-1:0]   wd_i;
  logic                   issue_i;
  logic [REGBITS-1:0]     issue_wa_i;
  logic [NREGS-1:0]       busy_o;

  regfile_sb #(
    .WIDTH   (WIDTH),
    .REGBITS (REGBITS),
    .NRD     (NRD),
    .NWR     (NWR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ra_i       (ra_i),
    .rd_o       (rd_o),
    .rd_busy_o  (rd_busy_o),
    .we_i       (we_i),
    .wa_i       (wa_i),
    .wd_i       (wd_i),
    .issue_i    (issue_i),
    .issue_wa_i (issue_wa_i),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  logic [WIDTH-1:0] m_mem  [NREGS];
  bit               m_busy [NREGS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: architectural register contents and pending flags.
  initial begin
    for (int i = 0; i < NREGS; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < NREGS; i++) begin
          m_mem[i]  = '0;
          m_busy[i] = 1'b0;
        end
      end else begin
        for (int p = 0; p < NWR; p++) begin
          int a;
          a = int'(wa_i[p*REGBITS +: REGBITS]);
          if (we_i[p] && a != 0) begin
            m_mem[a]  = wd_i[p*WIDTH +: WIDTH];
            m_busy[a] = 1'b0;
          end
        end
        if (issue_i && issue_wa_i != '0) m_busy[int'(issue_wa_i)] = 1'b1;
      end
    end
  end

  function automatic bit written_now(input int a);
    bit hit;
    hit = 1'b0;
    for (int p = 0; p < NWR; p++)
      if (we_i[p] && int'(wa_i[p*REGBITS +: REGBITS]) == a && a != 0) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [WIDTH-1:0] exp_rd(input int a);
    logic [WIDTH-1:0] v;
    if (rst || a == 0) return '0;
    v = m_mem[a];
    for (int p = 0; p < NWR; p++)
      if (we_i[p] && int'(wa_i[p*REGBITS +: REGBITS]) == a) v = wd_i[p*WIDTH +: WIDTH];
    return v;
  endfunction

  function automatic logic exp_rd_busy(input int a);
    if (rst || a == 0) return 1'b0;
    return m_busy[a] && !written_now(a);
  endfunction

  function automatic logic [NREGS-1:0] exp_busy();
    logic [NREGS-1:0] v;
    v = '0;
    for (int i = 1; i < NREGS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Every-cycle compare against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int k = 0; k < NRD; k++) begin
          int a;
          a = int'(ra_i[k*REGBITS +: REGBITS]);
          chk($sformatf("model rd_o[%0d] a=%0d", k, a), 64'(rd_o[k*WIDTH +: WIDTH]), 64'(exp_rd(a)));
          chk($sformatf("model rd_busy_o[%0d] a=%0d", k, a), 64'(rd_busy_o[k]), 64'(exp_rd_busy(a)));
        end
        chk("model busy_o", 64'(busy_o), 64'(exp_busy()));
      end
    end
  end

  task automatic idle();
    we_i       = '0;
    wa_i       = '0;
    wd_i       = '0;
    issue_i    = 1'b0;
    issue_wa_i = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [WIDTH-1:0] d);
    we_i[p]                      = 1'b1;
    wa_i[p*REGBITS +: REGBITS]   = REGBITS'(a);
    wd_i[p*WIDTH +: WIDTH]       = d;
  endtask

  task automatic iss(input int a);
    issue_i    = 1'b1;
    issue_wa_i = REGBITS'(a);
  endtask

  task automatic rd(input int k, input int a);
    ra_i[k*REGBITS +: REGBITS] = REGBITS'(a);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic logic [WIDTH-1:0] rdp(input int k);
    return rd_o[k*WIDTH +: WIDTH];
  endfunction

  initial begin
    idle();
    ra_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Reset state across all addresses on both ports.
    for (int a = 0; a < NREGS; a++) begin
      step();
      rd(0, a);
      rd(1, NREGS - 1 - a);
      #2;
      chk($sformatf("reset rd0 a=%0d", a), 64'(rdp(0)), 64'h0);
      chk($sformatf("reset rd1 a=%0d", NREGS - 1 - a), 64'(rdp(1)), 64'h0);
    end
    chk("reset busy_o", 64'(busy_o), 64'h0);

    // Same-register write on both ports: higher port wins, bypass and storage.
    step();
    wr(0, 3, 32'h11);
    wr(1, 3, 32'h22);
    rd(0, 3);
    #2;
    chk("dual write bypass r3", 64'(rdp(0)), 64'h22);
    step();
    #2;
    chk("dual write stored r3", 64'(rdp(0)), 64'h22);

    // Register 0 ignores writes and issues.
    step();
    wr(0, 0, 32'hFFFF_FFFF);
    iss(0);
    rd(0, 0);
    #2;
    chk("r0 bypass", 64'(rdp(0)), 64'h0);
    step();
    #2;
    chk("r0 stored", 64'(rdp(0)), 64'h0);
    chk("r0 busy", 64'(busy_o[0]), 64'h0);

    // Issue then retire r5.
    step();
    iss(5);
    step();
    rd(0, 5);
    #2;
    chk("r5 busy_o after issue", 64'(busy_o[5]), 64'h1);
    chk("r5 rd_busy after issue", 64'(rd_busy_o[0]), 64'h1);
    step();
    wr(0, 5, 32'hABCD);
    #2;
    chk("r5 rd_busy during write", 64'(rd_busy_o[0]), 64'h0);
    chk("r5 bypass data", 64'(rdp(0)), 64'hABCD);
    step();
    #2;
    chk("r5 busy_o cleared", 64'(busy_o[5]), 64'h0);

    // Simultaneous issue and write on r2, then re-issue of a busy register.
    step();
    iss(2);
    wr(0, 2, 32'h7);
    step();
    rd(1, 2);
    #2;
    chk("r2 data after issue+write", 64'(rdp(1)), 64'h7);
    chk("r2 busy after issue+write", 64'(busy_o[2]), 64'h1);
    step();
    iss(2);
    step();
    #2;
    chk("r2 busy after reissue", 64'(busy_o[2]), 64'h1);

    // Distinct registers on each write port, cross-read.
    step();
    wr(0, 6, 32'h66);
    wr(1, 7, 32'h77);
    rd(0, 7);
    rd(1, 6);
    #2;
    chk("cross bypass rd0 r7", 64'(rdp(0)), 64'h77);
    chk("cross bypass rd1 r6", 64'(rdp(1)), 64'h66);

    // Load r1..r7, issue r4, then reset between edges.
    for (int i = 1; i < NREGS; i++) begin
      step();
      wr(i % NWR, i, 32'h100 + i);
    end
    step();
    iss(4);
    step();
    rd(0, 4);
    rd(1, 1);
    #2;
    chk("preload r1", 64'(rdp(1)), 64'h101);
    rst = 1'b1;
    #1;
    chk("async reset rd0", 64'(rdp(0)), 64'h0);
    chk("async reset rd1", 64'(rdp(1)), 64'h0);
    chk("async reset busy_o", 64'(busy_o), 64'h0);
    chk("async reset rd_busy", 64'(rd_busy_o), 64'h0);
    wr(0, 6, 32'h99);
    rd(0, 6);
    #1;
    chk("write ignored in reset", 64'(rdp(0)), 64'h0);
    idle();
    #1;
    rst = 1'b0;
    step();
    #2;
    chk("r6 cleared by reset", 64'(rdp(0)), 64'h0);
    step();
    wr(0, 1, 32'h5);
    step();
    #2;
    chk("r1 after reset release", 64'(rdp(1)), 64'h5);

    step();
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
